// File: rtl/snax_hwpe_reg_slave.sv
// -----------------------------------------------------------------------------
// snax_hwpe_reg_slave
//
// Control/job register file of an HWPE-style accelerator. It sits behind the
// Snitch-to-HWPE bridge and serves its 32-bit peripheral request stream. It
// also runs a small start/run/done sequencer that drives the datapath.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   periph_req_i        request valid (always granted in the same cycle)
//   periph_add_i        byte address; the word index is add[AddrLsb +: 6]
//   periph_wen_i        1 = read, 0 = write
//   periph_be_i         byte enables for writes
//   periph_data_i       write data
//   periph_id_i         transaction id, echoed on read responses
//   periph_gnt_o        grant (combinational copy of periph_req_i)
//   periph_r_data_o     read data, one cycle after the read request
//   periph_r_valid_o    read response valid
//   periph_r_id_o       id of the read being answered
//   job_regs_o          flattened job registers, job 0 in the LSBs
//   start_o             one-cycle datapath start pulse
//   done_i              datapath completion pulse (only honoured in RUN)
//   busy_o              sequencer is not idle
//   irq_o               one-cycle completion event
//
// Register map (word index):
//   0 TRIGGER (wo), 1 STATUS (ro, {error, done_seen, busy}),
//   2 SOFT_CLEAR (wo), 3 PERF_CNT (ro), 4.. JOB registers (rw)
// -----------------------------------------------------------------------------
module snax_hwpe_reg_slave #(
    parameter int NumJobRegs = 8,
    parameter int AddrLsb    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       periph_req_i,
    input  logic [31:0]                periph_add_i,
    input  logic                       periph_wen_i,
    input  logic [3:0]                 periph_be_i,
    input  logic [31:0]                periph_data_i,
    input  logic [4:0]                 periph_id_i,
    output logic                       periph_gnt_o,
    output logic [31:0]                periph_r_data_o,
    output logic                       periph_r_valid_o,
    output logic [4:0]                 periph_r_id_o,
    output logic [32*NumJobRegs-1:0]   job_regs_o,
    output logic                       start_o,
    input  logic                       done_i,
    output logic                       busy_o,
    output logic                       irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [5:0] IDX_TRIGGER    = 6'd0;
    localparam logic [5:0] IDX_STATUS     = 6'd1;
    localparam logic [5:0] IDX_SOFT_CLEAR = 6'd2;
    localparam logic [5:0] IDX_PERF       = 6'd3;
    localparam logic [5:0] IDX_JOB_BASE   = 6'd4;

    // Byte-lane merge used by every byte-enabled register write.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] job_q [NumJobRegs];
    logic [31:0] job_d [NumJobRegs];
    logic [31:0] perf_q, perf_d;
    logic        error_q, error_d;
    logic        done_seen_q, done_seen_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;
    logic        busy_q, busy_d;
    logic        r_valid_q, r_valid_d;
    logic [31:0] r_data_q, r_data_d;
    logic [4:0]  r_id_q, r_id_d;

    logic [5:0]  idx_s;
    logic        wr_s;
    logic        rd_s;
    logic        trigger_wr_s;
    logic        soft_clr_s;
    logic        status_rd_s;
    logic        busy_s;
    logic [31:0] rdata_s;
    logic        unused_add_s;

    assign idx_s        = periph_add_i[AddrLsb +: 6];
    assign unused_add_s = ^periph_add_i;
    // A write with no byte enabled is granted but has no side effect at all.
    assign wr_s         = periph_req_i & ~periph_wen_i & (|periph_be_i);
    assign rd_s         = periph_req_i & periph_wen_i;
    assign trigger_wr_s = wr_s & (idx_s == IDX_TRIGGER);
    assign soft_clr_s   = wr_s & (idx_s == IDX_SOFT_CLEAR);
    assign status_rd_s  = rd_s & (idx_s == IDX_STATUS);
    assign busy_s       = (state_q != ST_IDLE);

    assign periph_gnt_o     = periph_req_i;
    assign periph_r_data_o  = r_data_q;
    assign periph_r_valid_o = r_valid_q;
    assign periph_r_id_o    = r_id_q;
    assign start_o          = start_q;
    assign irq_o            = irq_q;
    assign busy_o           = busy_q;

    // Sequencer next state; soft clear forces IDLE over anything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger_wr_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (done_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (soft_clr_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Pulses and busy are registered copies of the next state, so they
    // line up with the state register and vanish on a soft clear.
    always_comb begin
        start_d = (state_d == ST_START);
        irq_d   = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Status flags: error is sticky; done_seen is set on completion and
    // cleared by a STATUS read. A completion beats a same-cycle read so the
    // event is never lost.
    always_comb begin
        error_d     = error_q;
        done_seen_d = done_seen_q;
        if (soft_clr_s) begin
            error_d     = 1'b0;
            done_seen_d = 1'b0;
        end else begin
            if (trigger_wr_s && busy_s) begin
                error_d = 1'b1;
            end else begin
                error_d = error_q;
            end
            if (state_q == ST_DONE) begin
                done_seen_d = 1'b1;
            end else if (status_rd_s) begin
                done_seen_d = 1'b0;
            end else begin
                done_seen_d = done_seen_q;
            end
        end
    end

    // Busy-cycle counter: restarts at 1 in START (that cycle is counted),
    // saturates in RUN, holds otherwise.
    always_comb begin
        perf_d = perf_q;
        if (soft_clr_s) begin
            perf_d = 32'd0;
        end else if (state_q == ST_START) begin
            perf_d = 32'd1;
        end else if ((state_q == ST_RUN) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Job register writes; dropped while the sequencer is busy.
    always_comb begin
        for (int j = 0; j < NumJobRegs; j++) begin
            job_d[j] = job_q[j];
            if (soft_clr_s) begin
                job_d[j] = 32'd0;
            end else if (wr_s && !busy_s && (idx_s == IDX_JOB_BASE + 6'(j))) begin
                job_d[j] = merge_bytes(job_q[j], periph_data_i, periph_be_i);
            end else begin
                job_d[j] = job_q[j];
            end
        end
    end

    // Read mux over pre-update register state; unmapped indices read 0.
    always_comb begin
        rdata_s = 32'd0;
        case (idx_s)
            IDX_STATUS: rdata_s = {29'd0, error_q, done_seen_q, busy_s};
            IDX_PERF:   rdata_s = perf_q;
            default: begin
                for (int j = 0; j < NumJobRegs; j++) begin
                    if (idx_s == IDX_JOB_BASE + 6'(j)) begin
                        rdata_s = job_q[j];
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
    end

    // Read response channel inputs: only reads produce a response.
    always_comb begin
        r_valid_d = rd_s;
        if (rd_s) begin
            r_data_d = rdata_s;
            r_id_d   = periph_id_i;
        end else begin
            r_data_d = 32'd0;
            r_id_d   = 5'd0;
        end
    end

    // Flatten job registers onto the output bus, job 0 in the LSBs.
    always_comb begin
        job_regs_o = '0;
        for (int j = 0; j < NumJobRegs; j++) begin
            job_regs_o[32*j +: 32] = job_q[j];
        end
    end

    // State and register storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            perf_q      <= 32'd0;
            error_q     <= 1'b0;
            done_seen_q <= 1'b0;
            start_q     <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= 32'd0;
            r_id_q      <= 5'd0;
            for (int j = 0; j < NumJobRegs; j++) begin
                job_q[j] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            perf_q      <= perf_d;
            error_q     <= error_d;
            done_seen_q <= done_seen_d;
            start_q     <= start_d;
            irq_q       <= irq_d;
            busy_q      <= busy_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_id_q      <= r_id_d;
            for (int j = 0; j < NumJobRegs; j++) begin
                job_q[j] <= job_d[j];
            end
        end
    end

endmodule

// File: tb/tb_snax_hwpe_reg_slave.sv
// -----------------------------------------------------------------------------
// Bench for snax_hwpe_reg_slave. Reads push their expected {id, data} to a
// queue; a negedge monitor pops and compares whenever a response shows up,
// and checks r_valid against the reads the bench itself issued.
// -----------------------------------------------------------------------------
module tb_snax_hwpe_reg_slave;

    localparam int NJ = 8;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              periph_req_i;
    logic [31:0]       periph_add_i;
    logic              periph_wen_i;
    logic [3:0]        periph_be_i;
    logic [31:0]       periph_data_i;
    logic [4:0]        periph_id_i;
    logic              periph_gnt_o;
    logic [31:0]       periph_r_data_o;
    logic              periph_r_valid_o;
    logic [4:0]        periph_r_id_o;
    logic [32*NJ-1:0]  job_regs_o;
    logic              start_o;
    logic              done_i;
    logic              busy_o;
    logic              irq_o;

    int n_pass  = 0;
    int n_total = 0;
    int start_cnt = 0;
    int irq_cnt   = 0;
    logic rd_seen = 1'b0;
    logic [36:0] exp_q[$];

    snax_hwpe_reg_slave #(.NumJobRegs(NJ), .AddrLsb(2)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .periph_req_i     (periph_req_i),
        .periph_add_i     (periph_add_i),
        .periph_wen_i     (periph_wen_i),
        .periph_be_i      (periph_be_i),
        .periph_data_i    (periph_data_i),
        .periph_id_i      (periph_id_i),
        .periph_gnt_o     (periph_gnt_o),
        .periph_r_data_o  (periph_r_data_o),
        .periph_r_valid_o (periph_r_valid_o),
        .periph_r_id_o    (periph_r_id_o),
        .job_regs_o       (job_regs_o),
        .start_o          (start_o),
        .done_i           (done_i),
        .busy_o           (busy_o),
        .irq_o            (irq_o)
    );

    always #5 clk = ~clk;

    // Remember whether the bench issued a read this cycle.
    always @(posedge clk) begin
        rd_seen <= periph_req_i & periph_wen_i;
    end

    // Response monitor / scoreboard and pulse counters.
    always @(negedge clk) begin
        logic [36:0] e;
        if (start_o === 1'b1) start_cnt++;
        if (irq_o === 1'b1) irq_cnt++;
        n_total++;
        if (periph_r_valid_o !== rd_seen) begin
            $display("FAIL r_valid: got %b want %b at %0t", periph_r_valid_o, rd_seen, $time);
        end else begin
            n_pass++;
        end
        if (periph_r_valid_o === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_resp: got id %0d data %h, want none", periph_r_id_o, periph_r_data_o);
            end else begin
                e = exp_q.pop_front();
                if ({periph_r_id_o, periph_r_data_o} !== e) begin
                    $display("FAIL read_resp: got id %0d data %h want id %0d data %h",
                             periph_r_id_o, periph_r_data_o, e[36:32], e[31:0]);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] idx, input logic [3:0] be, input logic [31:0] d);
        periph_req_i  = 1'b1;
        periph_wen_i  = 1'b0;
        periph_add_i  = {24'd0, idx, 2'b00};
        periph_be_i   = be;
        periph_data_i = d;
        periph_id_i   = 5'd0;
        step(1);
        periph_req_i  = 1'b0;
        periph_be_i   = 4'd0;
    endtask

    task automatic rd(input logic [5:0] idx, input logic [4:0] id, input logic [31:0] exp);
        exp_q.push_back({id, exp});
        periph_req_i  = 1'b1;
        periph_wen_i  = 1'b1;
        periph_add_i  = {24'd0, idx, 2'b00};
        periph_be_i   = 4'd0;
        periph_id_i   = id;
        step(1);
        periph_req_i  = 1'b0;
        periph_wen_i  = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({start_o, busy_o, irq_o, periph_r_valid_o, periph_r_data_o, periph_r_id_o} !== 41'd0) begin
            $display("FAIL reset_outputs: got %b%b%b%b %h %h want all 0", start_o, busy_o, irq_o,
                     periph_r_valid_o, periph_r_data_o, periph_r_id_o);
        end else n_pass++;
        n_total++;
        if (job_regs_o !== '0) $display("FAIL reset_jobs: got %h want 0", job_regs_o);
        else n_pass++;
    endtask

    task automatic test_job_write();
        wr(6'd4, 4'hF, 32'hA5A5_A5A5);
        wr(6'd4, 4'h3, 32'h0000_FFFF);
        wr(6'd4, 4'h0, 32'h0000_0000);          // no lane enabled: no effect
        // Grant is combinational with the request.
        exp_q.push_back({5'd7, 32'hA5A5_FFFF});
        periph_req_i = 1'b1; periph_wen_i = 1'b1;
        periph_add_i = {24'd0, 6'd4, 2'b00}; periph_id_i = 5'd7;
        #1;
        n_total++;
        if (periph_gnt_o !== 1'b1) $display("FAIL gnt: got %b want 1", periph_gnt_o);
        else n_pass++;
        step(1);
        periph_req_i = 1'b0; periph_wen_i = 1'b0;
        #1;
        n_total++;
        if (periph_gnt_o !== 1'b0) $display("FAIL gnt_idle: got %b want 0", periph_gnt_o);
        else n_pass++;
        n_total++;
        if (job_regs_o[31:0] !== 32'hA5A5_FFFF) $display("FAIL job0_out: got %h want a5a5ffff", job_regs_o[31:0]);
        else n_pass++;
        // Last job register, mixed lanes, plus the out-of-range neighbour.
        wr(6'd11, 4'b1010, 32'h1122_3344);
        wr(6'd12, 4'hF, 32'hFFFF_FFFF);
        rd(6'd11, 5'd1, 32'h1100_3300);
        rd(6'd12, 5'd2, 32'h0);
        rd(6'd0, 5'd3, 32'h0);                  // TRIGGER reads as 0
        n_total++;
        if (job_regs_o[32*NJ-1 -: 32] !== 32'h1100_3300) $display("FAIL job7_out: got %h want 11003300", job_regs_o[32*NJ-1 -: 32]);
        else n_pass++;
    endtask

    task automatic test_run();
        wr(6'd0, 4'hF, 32'h1);                  // cycle N; now in N+1
        n_total++;
        if ({start_o, busy_o} !== 2'b11) $display("FAIL start_pulse: got start %b busy %b want 1 1", start_o, busy_o);
        else n_pass++;
        step(1);
        n_total++;
        if ({start_o, busy_o} !== 2'b01) $display("FAIL start_once: got start %b busy %b want 0 1", start_o, busy_o);
        else n_pass++;
        step(9);                                // N+11
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        n_total++;
        if (irq_o !== 1'b1) $display("FAIL irq: got %b want 1", irq_o);
        else n_pass++;
        step(1);
        n_total++;
        if ({irq_o, busy_o} !== 2'b00) $display("FAIL irq_end: got irq %b busy %b want 0 0", irq_o, busy_o);
        else n_pass++;
        rd(6'd3, 5'd4, 32'd11);
        rd(6'd1, 5'd5, 32'h2);
    endtask

    task automatic test_status_rtc();
        int ic;
        ic = irq_cnt;
        done_i = 1'b1;                          // outside RUN: ignored
        step(2);
        done_i = 1'b0;
        step(1);
        n_total++;
        if (irq_cnt != ic || busy_o !== 1'b0) $display("FAIL done_idle: got irqs %0d busy %b want %0d 0", irq_cnt, busy_o, ic);
        else n_pass++;
        wr(6'd0, 4'hF, 32'h0);
        step(1);
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        step(1);
        rd(6'd1, 5'd6, 32'h2);
        rd(6'd1, 5'd8, 32'h0);
    endtask

    task automatic test_busy_protect();
        int sc;
        sc = start_cnt;
        wr(6'd0, 4'hF, 32'h0);
        step(1);
        wr(6'd5, 4'hF, 32'h0000_1234);
        wr(6'd0, 4'hF, 32'h0);
        rd(6'd1, 5'd9, 32'h5);
        rd(6'd5, 5'd10, 32'h0);
        step(1);
        n_total++;
        if (job_regs_o[63:32] !== 32'h0) $display("FAIL job1_protect: got %h want 0", job_regs_o[63:32]);
        else n_pass++;
        n_total++;
        if (start_cnt - sc != 1) $display("FAIL start_count: got %0d want 1", start_cnt - sc);
        else n_pass++;
    endtask

    task automatic test_soft_clear();
        int ic;
        ic = irq_cnt;
        rd(6'd1, 5'd11, 32'h5);                 // response lands in the clear cycle
        periph_req_i = 1'b1; periph_wen_i = 1'b0;
        periph_add_i = {24'd0, 6'd2, 2'b00}; periph_be_i = 4'hF; periph_data_i = 32'h0;
        done_i = 1'b1;
        step(1);
        periph_req_i = 1'b0; periph_be_i = 4'h0; done_i = 1'b0;
        n_total++;
        if ({busy_o, irq_o, start_o} !== 3'b000) $display("FAIL soft_clear: got busy %b irq %b start %b want 0 0 0", busy_o, irq_o, start_o);
        else n_pass++;
        step(2);
        n_total++;
        if (irq_cnt != ic) $display("FAIL soft_clear_irq: got %0d irqs want 0", irq_cnt - ic);
        else n_pass++;
        rd(6'd4, 5'd12, 32'h0);
        rd(6'd3, 5'd13, 32'h0);
        rd(6'd1, 5'd14, 32'h0);
        n_total++;
        if (job_regs_o !== '0) $display("FAIL soft_clear_jobs: got %h want 0", job_regs_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int ic;
        wr(6'd4, 4'hF, 32'hDEAD_BEEF);
        wr(6'd0, 4'hF, 32'h0);
        step(1);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL run_before_reset: got busy %b want 1", busy_o);
        else n_pass++;
        ic = irq_cnt;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if ({start_o, busy_o, irq_o, periph_r_valid_o} !== 4'd0 || job_regs_o !== '0)
            $display("FAIL async_reset: got %b%b%b%b jobs %h want 0", start_o, busy_o, irq_o, periph_r_valid_o, job_regs_o);
        else n_pass++;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        step(2);
        n_total++;
        if (irq_cnt != ic || busy_o !== 1'b0) $display("FAIL reset_done: got irqs %0d busy %b want 0 0", irq_cnt - ic, busy_o);
        else n_pass++;
        rd(6'd40, 5'd15, 32'h0);
        rd(6'd3, 5'd16, 32'h0);
        step(2);
    endtask

    initial begin
        rst_ni = 1'b0;
        periph_req_i = 1'b0; periph_add_i = 32'd0; periph_wen_i = 1'b0;
        periph_be_i = 4'd0; periph_data_i = 32'd0; periph_id_i = 5'd0;
        done_i = 1'b0;
        step(2);
        test_reset();
        rst_ni = 1'b1;
        step(1);
        test_job_write();
        test_run();
        test_status_rtc();
        test_busy_protect();
        test_soft_clear();
        test_reset_mid_run();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL pending_reads: got %0d left want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
